fb_stream_axi_writer: RTL and testbench
=======================================

Name: fb_stream_axi_writer

Overview:
- Receiving end of the framebuffer AXI Stream emitted by RasterIX (m_framebuffer_axis_*); writes each streamed frame linearly into memory through an AXI4 write-only master.
- Sits between the rasterizer's framebuffer stream and the shared AXI memory, for example an axi_ram behind an interconnect.
- Buffers one burst of beats, issues AW, drains W, waits for B, then repeats until tlast closes the frame.

Parameters:
- DATA_WIDTH, 32, stream and AXI data width in bits; must be a multiple of 8.
- ADDR_WIDTH, 25, AXI byte address width.
- ID_WIDTH, 8, AXI ID width.
- BURST_LEN, 16, maximum beats per burst; power of two, 2..256; BURST_LEN*DATA_WIDTH/8 must be ≤ 4096.
- AXI_ID, 0, constant awid value.

Ports:
- aclk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- frame_base  in  ADDR_WIDTH  byte address of the frame; sampled on the first accepted beat of each frame; must be aligned to BURST_LEN*DATA_WIDTH/8
- s_fb_axis_tvalid  in  1  stream beat valid
- s_fb_axis_tready  out  1  stream beat ready
- s_fb_axis_tlast  in  1  last beat of frame
- s_fb_axis_tdata  in  DATA_WIDTH  pixel data
- m_axi_awid/awaddr/awlen/awsize/awburst/awlock/awcache/awprot/awvalid  out  ID_WIDTH/ADDR_WIDTH/8/3/2/1/4/3/1  AXI4 write address channel
- m_axi_awready  in  1
- m_axi_wdata/wstrb/wlast/wvalid  out  DATA_WIDTH/DATA_WIDTH/8/1/1  AXI4 write data channel
- m_axi_wready  in  1
- m_axi_bid  in  ID_WIDTH
- m_axi_bresp  in  2
- m_axi_bvalid  in  1
- m_axi_bready  out  1
- frame_done  out  1  one-cycle pulse after the B response of the frame's final burst
- write_error  out  1  sticky flag; set on any bresp != 2'b00; cleared only by reset
- busy  out  1  high from the first accepted beat until frame_done

Behaviour:
- Async reset (resetn low): state=FILL, address and counters=0, FIFO empty. Outputs go low: awvalid, wvalid, bready, s_fb_axis_tready, frame_done, busy, write_error.
- Constant outputs:
  - awsize=log2(DATA_WIDTH/8), awburst=INCR (2'b01), awlock=0, awcache=4'b0011, awprot=0, awid=AXI_ID.
  - wstrb all ones.
- Internal FIFO depth is BURST_LEN. Registered count cnt (0..BURST_LEN) and registered flag last_seen.
- State FILL:
  - s_fb_axis_tready = (cnt < BURST_LEN) and !last_seen.
  - On a beat handshake: push tdata and increment cnt.
  - If the beat is the first of a frame (busy=0): latch addr=frame_base and set busy.
  - If tlast: set last_seen.
  - Transition to AW when cnt==BURST_LEN or last_seen (evaluated on registered values, i.e. the cycle after the filling beat).
- State AW:
  - awvalid=1, awaddr=addr, awlen=cnt-1, all held stable until awready.
  - On handshake go to W. awvalid drops the same edge.
- State W:
  - wvalid=1 while the FIFO is not empty.
  - wlast=1 on the beat where the remaining count equals 1.
  - Pop on wvalid&wready. On the wlast handshake go to B.
  - No W beat is ever presented before the AW handshake.
- State B:
  - bready=1. On bvalid: if bresp!=0 set write_error; addr += burst_beats*DATA_WIDTH/8 (modulo 2^ADDR_WIDTH).
  - If last_seen: pulse frame_done the next cycle, clear busy and last_seen, return to FILL.
  - Otherwise return to FILL.
- Input is not accepted outside FILL, so the stream stalls for the duration of AW/W/B.
- Boundaries:
  - 1-beat frame (tlast on first beat) yields awlen=0 and a single wlast beat.
  - A frame of exactly k*BURST_LEN beats yields k full bursts and no empty trailing burst.
  - tlast arriving with cnt==BURST_LEN-1 fills the FIFO and sets last_seen on the same beat.
  - awready/wready/bvalid may be held low indefinitely; all outputs stay stable.
  - frame_base changes mid-frame are ignored.
  - A reset mid-burst abandons the transaction immediately (valids low); the downstream slave is expected to be reset together with this block.
- Latency: first AW asserts 2 cycles after the handshake of the beat that completes the burst or carries tlast.

Test Plan:
- BURST_LEN=16, frame_base=0x1000, 40-beat frame, data=index, all readies high → three bursts:
  - AW 0x1000/len 15, AW 0x1040/len 15, AW 0x1080/len 7.
  - RAM words 0x1000.. hold 0..39, one frame_done pulse, write_error=0.
- 1-beat frame, tdata=0xDEADBEEF, frame_base=0x200 → single AW 0x200 awlen=0, one W beat with wlast=1, frame_done once.
- 32-beat frame → exactly two bursts of len 15; no third AW; busy falls with frame_done.
- Random stalls (awready/wready/bvalid low 0–7 cycles, tvalid gaps) on 40-beat frame → identical memory contents; AW/W signals stable while stalled; no W before AW.
- bresp=2'b10 on second burst of 40-beat frame → write_error set and stays set, frame still completes with frame_done.
- Assert resetn low during W of burst 2 → awvalid/wvalid/bready/tready low immediately. Next frame at 0x3000 writes correctly starting at 0x3000.

Source files
------------

// File: rtl/fb_stream_axi_writer_if.sv
// fb_stream_axi_writer_if: AXI4 write-only channel bundle (AW, W, B) between the framebuffer writer and memory
interface fb_stream_axi_writer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 25,
    parameter int ID_WIDTH   = 8
);
    logic [ID_WIDTH-1:0]     awid;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awlock;
    logic [3:0]              awcache;
    logic [2:0]              awprot;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;
    logic [ID_WIDTH-1:0]     bid;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output wdata, wstrb, wlast, wvalid, bready,
        input  awready, wready, bid, bresp, bvalid
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  wdata, wstrb, wlast, wvalid, bready,
        output awready, wready, bid, bresp, bvalid
    );
endinterface

// File: rtl/fb_stream_axi_writer.sv
// fb_stream_axi_writer: buffers framebuffer stream beats into bursts and writes them linearly via AXI4
module fb_stream_axi_writer #(
    parameter int                DATA_WIDTH = 32,
    parameter int                ADDR_WIDTH = 25,
    parameter int                ID_WIDTH   = 8,
    parameter int                BURST_LEN  = 16,
    parameter logic [ID_WIDTH-1:0] AXI_ID   = '0
) (
    input  logic                  aclk,
    input  logic                  resetn,
    input  logic [ADDR_WIDTH-1:0] frame_base,
    input  logic                  s_fb_axis_tvalid,
    output logic                  s_fb_axis_tready,
    input  logic                  s_fb_axis_tlast,
    input  logic [DATA_WIDTH-1:0] s_fb_axis_tdata,
    fb_stream_axi_writer_if.master m_axi,
    output logic                  frame_done,
    output logic                  write_error,
    output logic                  busy
);
    localparam int CW = $clog2(BURST_LEN + 1);
    localparam int IW = $clog2(BURST_LEN);
    localparam int SZ = $clog2(DATA_WIDTH / 8);

    typedef enum logic [1:0] {FILL, AW, W, B} state_t;

    state_t                state, state_nx;
    logic [DATA_WIDTH-1:0] mem [BURST_LEN];
    logic [ADDR_WIDTH-1:0] addr;
    logic [CW-1:0]         cnt, blen;
    logic                  last_seen, en, push, pop, b_hs;

    assign push = s_fb_axis_tvalid && s_fb_axis_tready;
    assign pop  = m_axi.wvalid && m_axi.wready;
    assign b_hs = m_axi.bvalid && m_axi.bready;

    assign m_axi.awid    = AXI_ID;
    assign m_axi.awaddr  = addr;
    assign m_axi.awlen   = 8'(cnt - CW'(1));
    assign m_axi.awsize  = 3'(SZ);
    assign m_axi.awburst = 2'b01;
    assign m_axi.awlock  = 1'b0;
    assign m_axi.awcache = 4'b0011;
    assign m_axi.awprot  = 3'b000;
    // cnt counts down while draining, so blen - cnt is the read index
    assign m_axi.wdata   = mem[IW'(blen - cnt)];
    assign m_axi.wstrb   = '1;
    assign m_axi.wlast   = cnt == CW'(1);

    always_ff @(posedge aclk or negedge resetn)
        if (!resetn) state <= FILL;
        else         state <= state_nx;

    always_comb begin
        state_nx         = state;
        s_fb_axis_tready = 1'b0;
        m_axi.awvalid    = 1'b0;
        m_axi.wvalid     = 1'b0;
        m_axi.bready     = 1'b0;
        case (state)
            FILL: begin
                s_fb_axis_tready = en && cnt < CW'(BURST_LEN) && !last_seen;
                if (cnt == CW'(BURST_LEN) || last_seen) state_nx = AW;
            end
            AW: begin
                m_axi.awvalid = 1'b1;
                if (m_axi.awready) state_nx = W;
            end
            W: begin
                m_axi.wvalid = cnt != '0;
                if (pop && m_axi.wlast) state_nx = B;
            end
            B: begin
                m_axi.bready = 1'b1;
                if (m_axi.bvalid) state_nx = FILL;
            end
        endcase
    end

    always_ff @(posedge aclk)
        if (push) mem[IW'(cnt)] <= s_fb_axis_tdata;

    // en keeps tready low while reset is held
    always_ff @(posedge aclk or negedge resetn)
        if (!resetn) begin
            addr        <= '0;
            cnt         <= '0;
            blen        <= '0;
            last_seen   <= 1'b0;
            busy        <= 1'b0;
            write_error <= 1'b0;
            frame_done  <= 1'b0;
            en          <= 1'b0;
        end else begin
            en         <= 1'b1;
            frame_done <= 1'b0;
            if (push) begin
                cnt <= cnt + CW'(1);
                if (!busy) begin
                    addr <= frame_base;
                    busy <= 1'b1;
                end
                if (s_fb_axis_tlast) last_seen <= 1'b1;
            end
            if (m_axi.awvalid && m_axi.awready) blen <= cnt;
            if (pop) cnt <= cnt - CW'(1);
            if (b_hs) begin
                write_error <= write_error || m_axi.bresp != 2'b00;
                addr        <= addr + (ADDR_WIDTH'(blen) << SZ);
                if (last_seen) begin
                    frame_done <= 1'b1;
                    busy       <= 1'b0;
                    last_seen  <= 1'b0;
                end
            end
        end
endmodule

// File: tb/tb_fb_stream_axi_writer.sv
// tb_fb_stream_axi_writer: directed frames into the writer with a stalling AXI RAM model
module tb_fb_stream_axi_writer;
    logic        aclk = 1'b0;
    logic        resetn = 1'b0;
    logic [24:0] frame_base;
    logic        tvalid, tready, tlast;
    logic [31:0] tdata;
    logic        frame_done, write_error, busy;

    fb_stream_axi_writer_if axi ();

    fb_stream_axi_writer dut (
        .aclk(aclk), .resetn(resetn), .frame_base(frame_base),
        .s_fb_axis_tvalid(tvalid), .s_fb_axis_tready(tready),
        .s_fb_axis_tlast(tlast), .s_fb_axis_tdata(tdata),
        .m_axi(axi), .frame_done(frame_done), .write_error(write_error), .busy(busy)
    );

    always #5 aclk = ~aclk;

    int vectors = 0, miscompares = 0;
    logic [31:0] mem [logic [24:0]];
    logic [24:0] aw_log_addr [$], pend_addr [$];
    int          aw_log_len [$], pend_len [$];
    int wbeat = 0, b_owed = 0, b_idx = 0, err_burst = -1, fd_cnt = 0, w_beats = 0, w_lasts = 0;
    int stab_err = 0, order_err = 0, wl_err = 0, fd_busy_err = 0;
    bit stall = 0, abort = 0, b_fire = 0, prev_aw_stall = 0, prev_w_stall = 0;
    logic [24:0] prev_awaddr;
    logic [7:0]  prev_awlen;
    logic [31:0] prev_wdata;
    logic        prev_wlast;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rd(input logic [24:0] a);
        return mem.exists(a) ? mem[a] : 32'hx;
    endfunction

    // Slave decisions are made at the negedge; a handshake seen there fires on the next posedge
    initial begin
        axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.bresp = 0; axi.bid = 0;
        forever begin
            @(negedge aclk);
            if (frame_done) begin
                fd_cnt++;
                if (busy) fd_busy_err++;
            end
            if (!resetn) begin
                axi.awready = 0; axi.wready = 0; axi.bvalid = 0;
                pend_addr.delete(); pend_len.delete();
                wbeat = 0; b_owed = 0; b_fire = 0; prev_aw_stall = 0; prev_w_stall = 0;
            end else begin
                if (prev_aw_stall && (!axi.awvalid || axi.awaddr != prev_awaddr || axi.awlen != prev_awlen)) stab_err++;
                if (prev_w_stall && (!axi.wvalid || axi.wdata != prev_wdata || axi.wlast != prev_wlast)) stab_err++;
                if (axi.wvalid && pend_addr.size() == 0) order_err++;
                if (b_fire) begin
                    axi.bvalid = 0;
                    b_fire = 0;
                end
                axi.awready = !stall || $urandom_range(0, 3) == 0;
                axi.wready  = !stall || $urandom_range(0, 3) == 0;
                if (!axi.bvalid && b_owed > 0 && (!stall || $urandom_range(0, 3) == 0)) begin
                    axi.bvalid = 1;
                    axi.bresp = (b_idx == err_burst) ? 2'b10 : 2'b00;
                    b_idx++;
                    b_owed--;
                end
                if (axi.awvalid && axi.awready) begin
                    aw_log_addr.push_back(axi.awaddr); aw_log_len.push_back(int'(axi.awlen));
                    pend_addr.push_back(axi.awaddr); pend_len.push_back(int'(axi.awlen));
                end
                if (axi.wvalid && axi.wready && pend_addr.size() > 0) begin
                    mem[pend_addr[0] + 25'(4 * wbeat)] = axi.wdata;
                    w_beats++;
                    if (axi.wlast != (wbeat == pend_len[0])) wl_err++;
                    wbeat++;
                    if (axi.wlast) begin
                        w_lasts++;
                        void'(pend_addr.pop_front()); void'(pend_len.pop_front());
                        wbeat = 0;
                        b_owed++;
                    end
                end
                if (axi.bvalid && axi.bready) b_fire = 1;
                prev_aw_stall = axi.awvalid && !axi.awready;
                prev_w_stall  = axi.wvalid && !axi.wready;
                prev_awaddr = axi.awaddr; prev_awlen = axi.awlen;
                prev_wdata = axi.wdata; prev_wlast = axi.wlast;
            end
        end
    end

    task automatic clear_log();
        aw_log_addr.delete(); aw_log_len.delete();
        fd_cnt = 0; b_idx = 0; w_beats = 0; w_lasts = 0;
    endtask

    // frame_base is scrambled after the first beat to show it is only sampled once
    task automatic send_frame(input int n, input logic [24:0] base, input logic [31:0] d0, input bit gaps);
        for (int i = 0; i < n && !abort; i++) begin
            int to = 0;
            @(negedge aclk);
            if (gaps) repeat ($urandom_range(0, 3)) @(negedge aclk);
            frame_base = (i == 0) ? base : 25'h0badc0;
            tvalid = 1; tdata = d0 + 32'(i); tlast = (i == n - 1);
            while (!tready && !abort && to < 1000) begin
                @(negedge aclk);
                to++;
            end
            if (to >= 1000) begin
                chk("stream_timeout", 32'(to), 32'(0));
                abort = 1;
            end
            if (!abort) begin
                @(posedge aclk);
                #1;
            end
            tvalid = 0; tlast = 0;
        end
        tvalid = 0; tlast = 0;
    endtask

    task automatic wait_done(input int exp);
        int t = 0;
        while (fd_cnt < exp && t < 2000) begin
            @(negedge aclk);
            t++;
        end
        repeat (3) @(negedge aclk);
        chk("frame_done_count", 32'(fd_cnt), 32'(exp));
    endtask

    task automatic check_aw(input int i, input logic [24:0] a, input int l);
        chk($sformatf("aw%0d_addr", i), aw_log_addr.size() > i ? 32'(aw_log_addr[i]) : 32'hx, 32'(a));
        chk($sformatf("aw%0d_len", i), aw_log_len.size() > i ? 32'(aw_log_len[i]) : 32'hx, 32'(l));
    endtask

    task automatic check_mem(input logic [24:0] base, input int n, input logic [31:0] d0);
        for (int i = 0; i < n; i++)
            chk($sformatf("mem_%h", base + 25'(4 * i)), rd(base + 25'(4 * i)), d0 + 32'(i));
    endtask

    initial begin
        int t;
        tvalid = 0; tlast = 0; tdata = 0; frame_base = 0;
        repeat (3) @(negedge aclk);
        chk("rst_awvalid", 32'(axi.awvalid), 0);
        chk("rst_wvalid", 32'(axi.wvalid), 0);
        chk("rst_bready", 32'(axi.bready), 0);
        chk("rst_tready", 32'(tready), 0);
        chk("rst_frame_done", 32'(frame_done), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_write_error", 32'(write_error), 0);
        chk("awsize", 32'(axi.awsize), 2);
        chk("awburst", 32'(axi.awburst), 1);
        chk("awcache", 32'(axi.awcache), 3);
        chk("awlock_awprot_awid", {axi.awlock, axi.awprot, axi.awid}, 0);
        chk("wstrb", 32'(axi.wstrb), 32'hf);
        resetn = 1;

        // 40 beats: two full bursts and one of 8
        clear_log();
        send_frame(40, 25'h1000, 0, 0);
        wait_done(1);
        chk("t1_aw_count", 32'(aw_log_addr.size()), 3);
        check_aw(0, 25'h1000, 15);
        check_aw(1, 25'h1040, 15);
        check_aw(2, 25'h1080, 7);
        check_mem(25'h1000, 40, 0);
        chk("t1_write_error", 32'(write_error), 0);
        chk("t1_busy", 32'(busy), 0);

        clear_log();
        send_frame(1, 25'h200, 32'hdeadbeef, 0);
        wait_done(1);
        chk("t2_aw_count", 32'(aw_log_addr.size()), 1);
        check_aw(0, 25'h200, 0);
        chk("t2_w_beats", 32'(w_beats), 1);
        chk("t2_w_lasts", 32'(w_lasts), 1);
        chk("t2_mem", rd(25'h200), 32'hdeadbeef);

        clear_log();
        send_frame(32, 25'h2000, 32'h100, 0);
        chk("t3_busy_mid", 32'(busy), 1);
        wait_done(1);
        chk("t3_aw_count", 32'(aw_log_addr.size()), 2);
        check_aw(0, 25'h2000, 15);
        check_aw(1, 25'h2040, 15);
        chk("t3_busy_with_done", 32'(fd_busy_err), 0);
        chk("t3_busy", 32'(busy), 0);
        check_mem(25'h2000, 32, 32'h100);

        clear_log();
        stall = 1;
        send_frame(40, 25'h4000, 32'ha000, 1);
        wait_done(1);
        stall = 0;
        chk("t4_aw_count", 32'(aw_log_addr.size()), 3);
        check_aw(2, 25'h4080, 7);
        check_mem(25'h4000, 40, 32'ha000);

        clear_log();
        err_burst = 1;
        send_frame(40, 25'h5000, 32'h5000, 0);
        wait_done(1);
        chk("t5_write_error", 32'(write_error), 1);
        err_burst = -1;
        clear_log();
        send_frame(1, 25'h7000, 32'h77, 0);
        wait_done(1);
        chk("t5_error_sticky", 32'(write_error), 1);

        // reset lands in the middle of the second burst's data phase
        clear_log();
        fork
            send_frame(40, 25'h6000, 32'h6000, 0);
            begin
                t = 0;
                while (!(aw_log_addr.size() >= 2 && axi.wvalid) && t < 2000) begin
                    @(negedge aclk);
                    t++;
                end
                if (t >= 2000) chk("t6_reset_trigger", 32'(t), 0);
                #2 resetn = 0;
                abort = 1;
                #1;
                chk("t6_awvalid", 32'(axi.awvalid), 0);
                chk("t6_wvalid", 32'(axi.wvalid), 0);
                chk("t6_bready", 32'(axi.bready), 0);
                chk("t6_tready", 32'(tready), 0);
            end
        join
        repeat (3) @(negedge aclk);
        chk("t6_error_cleared", 32'(write_error), 0);
        chk("t6_busy_cleared", 32'(busy), 0);
        resetn = 1;
        abort = 0;
        clear_log();
        send_frame(20, 25'h3000, 32'h3000, 0);
        wait_done(1);
        chk("t6_aw_count", 32'(aw_log_addr.size()), 2);
        check_aw(0, 25'h3000, 15);
        check_aw(1, 25'h3040, 3);
        check_mem(25'h3000, 20, 32'h3000);

        chk("aw_w_stable_when_stalled", 32'(stab_err), 0);
        chk("w_before_aw", 32'(order_err), 0);
        chk("wlast_position", 32'(wl_err), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
